// File: rtl/pattern_detector_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package pattern_detector_pkg;

    // Width needed to hold a length in 0..pat_w.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    localparam logic [7:0] LEGACY_PATTERN = 8'b0000_0101;
    localparam int         LEGACY_LEN     = 3;

endpackage

// File: rtl/pattern_detector_window.sv
// Serial history window with fill tracking and a length-masked pattern compare.
module pattern_window
    import pattern_detector_pkg::*;
#(
    parameter int PAT_W = 8,
    localparam int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clear,
    input  logic             restart,
    input  logic             bit_in,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pat,
    output logic             hit,
    output logic             armed
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_n;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_n;
    logic [PAT_W-1:0] mask;

    assign hist_n = {hist[PAT_W-2:0], bit_in};
    assign fill_n = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(len)) mask[i] = 1'b1;
        end
    end

    // Compare is evaluated against the window as it will look after this bit.
    assign hit = shift && (len != '0) && (fill_n >= len) &&
                 ((hist_n & mask) == (pat & mask));

    assign armed = (len != '0) && (fill >= len);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_n;
            fill <= restart ? '0 : fill_n;
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Programmable serial bit-pattern detector with overlap control and saturating match counter.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int               PAT_W       = 8,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(LEGACY_PATTERN),
    parameter int               RST_LEN     = LEGACY_LEN,
    parameter logic             RST_OVERLAP = 1'b1,
    localparam int              LEN_W       = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic             ovl;
    logic             shift;
    logic             hit;
    logic [LEN_W-1:0] len_clamped;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign shift       = in_valid && !cfg_load;
    assign len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

    pattern_window #(.PAT_W(PAT_W)) u_window (
        .clk     (clk),
        .rst     (rst),
        .shift   (shift),
        .clear   (cfg_load),
        .restart (hit && !ovl),
        .bit_in  (in_bit),
        .len     (len),
        .pat     (pat),
        .hit     (hit),
        .armed   (armed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pat         <= RST_PATTERN;
            len         <= LEN_W'(RST_LEN);
            ovl         <= RST_OVERLAP;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= hit;
            if (cfg_load) begin
                pat <= cfg_pattern;
                len <= len_clamped;
                ovl <= cfg_overlap;
            end
            // Clear beats a simultaneous hit; the match pulse still fires.
            if (cnt_clr)  match_count <= '0;
            else if (hit) match_count <= sat_inc(match_count);
        end
    end

endmodule

// File: tb/tb_pattern_detector.sv
// Randomized and directed checks of pattern_detector against a sequence-level model.
module tb_pattern_detector;

    localparam int PAT_W = 8;
    localparam int CNT_W = 3;
    localparam int LEN_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             match, armed;
    logic [CNT_W-1:0] match_count;

    pattern_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match), .match_count(match_count), .armed(armed)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: bits accepted since the last restart, counted as "fresh" bits.
    int         m_len, m_ovl, m_fresh, m_cnt;
    logic [7:0] m_pat;
    logic       m_match;
    int         m_bits[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic r, ld, v, b, clr, input logic [7:0] p,
                         input int l, input logic o);
        logic h;
        h = 1'b0;
        if (r) begin
            m_len = 3; m_pat = 8'b101; m_ovl = 1; m_fresh = 0; m_cnt = 0;
            m_bits.delete();
            m_match = 1'b0;
            return;
        end
        if (ld) begin
            m_len = (l > PAT_W) ? PAT_W : l;
            m_pat = p; m_ovl = o; m_fresh = 0;
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(int'(b));
            if (m_bits.size() > 16) void'(m_bits.pop_front());
            if (m_fresh < 1000) m_fresh++;
            if (m_len > 0 && m_fresh >= m_len) begin
                h = 1'b1;
                // The most recent bit is compared with pattern bit 0.
                for (int i = 0; i < m_len; i++)
                    if (m_bits[m_bits.size() - 1 - i] != int'(m_pat[i])) h = 1'b0;
            end
            if (h && m_ovl == 0) m_fresh = 0;
        end
        m_match = h;
        if (clr) m_cnt = 0;
        else if (h && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic step(input logic r, ld, v, b, clr, input logic [7:0] p,
                        input logic [3:0] l, input logic o);
        rst = r; cfg_load = ld; in_valid = v; in_bit = b; cnt_clr = clr;
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        @(posedge clk);
        model(r, ld, v, b, clr, p, int'(l), o);
        #1;
        chk("match", match, m_match);
        chk("match_count", match_count, m_cnt);
        chk("armed", armed, (m_len != 0 && m_fresh >= m_len));
    endtask

    task automatic feed(input logic b);
        step(0, 0, 1, b, 0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic idle();
        step(0, 0, 0, 1'($urandom), 0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        step(0, 1, 0, 0, 1, p, l, o);
    endtask

    initial begin
        // Reset and legacy default 101 with overlap
        step(1, 0, 0, 0, 0, 8'h00, 4'd0, 1'b0);
        step(1, 0, 1, 1, 0, 8'h00, 4'd0, 1'b0);
        chk("rst_match", match, 0);
        chk("rst_count", match_count, 0);
        chk("rst_armed", armed, 0);
        feed(1); feed(0); feed(1);
        chk("legacy_first_hit", match, 1);
        feed(0); feed(1);
        chk("legacy_count", match_count, 2);

        // Non-overlapping 101
        load(8'b101, 4'd3, 1'b0);
        feed(1); feed(0); feed(1); feed(0); feed(1);
        chk("novl_count_a", match_count, 1);
        load(8'b101, 4'd3, 1'b0);
        feed(1); feed(0); feed(1); feed(1); feed(0); feed(1);
        chk("novl_count_b", match_count, 2);

        // 1101 with a two-cycle gap
        load(8'b1101, 4'd4, 1'b1);
        feed(1); feed(1); idle(); idle(); feed(0); feed(1);
        chk("gap_match", match, 1);
        chk("gap_count", match_count, 1);

        // Length 1, saturation, then clear with a simultaneous hit
        load(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 9; i++) feed(1);
        chk("sat_count", match_count, CMAX);
        step(0, 0, 1, 1, 1, 8'h00, 4'd0, 1'b0);
        chk("clr_hit_match", match, 1);
        chk("clr_hit_count", match_count, 0);

        // Length 0 never matches
        load(8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 20; i++) feed(1'($urandom));
        chk("len0_count", match_count, 0);

        // Oversized length clamps to PAT_W
        load(8'hA5, 4'd11, 1'b1);
        for (int i = 7; i >= 0; i--) feed(((8'hA5 >> i) & 8'h01) != 0);
        chk("clamp_match", match, 1);

        // Bit offered together with cfg_load is dropped
        step(0, 1, 1, 1, 1, 8'b101, 4'd3, 1'b1);
        feed(0); feed(1);
        chk("load_drop_count", match_count, 0);

        // Mid-stream reset loses the partial window
        load(8'b110, 4'd3, 1'b1);
        feed(1); feed(0);
        step(1, 0, 1, 1, 0, 8'h00, 4'd0, 1'b0);
        chk("midrst_match", match, 0);
        chk("midrst_count", match_count, 0);
        chk("midrst_armed", armed, 0);
        feed(1);
        chk("midrst_nohit", match, 0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            int sel;
            sel = $urandom_range(0, 199);
            if (sel == 0)
                step(1, 0, 1'($urandom), 1'($urandom), 0, 8'h00, 4'd0, 1'b0);
            else if (sel < 6)
                step(0, 1, 1'($urandom), 1'($urandom), 1'($urandom),
                     8'($urandom), ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4)),
                     1'($urandom));
            else
                step(0, 0, ($urandom_range(0, 3) != 0), 1'($urandom),
                     ($urandom_range(0, 29) == 0), 8'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
